hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage pipeline. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and resolves three kinds of event: load-use hazards, branches taken in MEM, and multi-cycle data-memory accesses over a req/ready handshake. It also keeps a saturating stall-cycle counter and latches a memory-timeout error.

---
 rtl/hazard_stall_ctrl_if.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 61 ++++++
 tb/tb_hazard_stall_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline event inputs and stage control outputs of the stall controller
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic id_uses_rt, ex_mem_read, mem_branch, mem_zero_flag;
    logic mem_mem_read, mem_mem_write, dmem_ready, clr_cnt;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic pc_src, dmem_req, timeout_err;
    logic [CNT_W-1:0] stall_count;
    modport master(
        output id_rs, id_rt, ex_write_reg, id_uses_rt, ex_mem_read, mem_branch, mem_zero_flag,
               mem_mem_read, mem_mem_write, dmem_ready, clr_cnt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
               mem_wb_flush, pc_src, dmem_req, timeout_err, stall_count
    );
    modport slave(
        input  id_rs, id_rt, ex_write_reg, id_uses_rt, ex_mem_read, mem_branch, mem_zero_flag,
               mem_mem_read, mem_mem_write, dmem_ready, clr_cnt,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
               mem_wb_flush, pc_src, dmem_req, timeout_err, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: 5-stage pipeline enables/flushes for load-use, taken branch and waited memory access
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst,
    hazard_stall_ctrl_if.slave ctrl_if
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    state_t state_q, state_d;
    logic [4:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic mem_acc, lu, taken, freeze, adv, err, stall;
    assign mem_acc = ctrl_if.mem_mem_read | ctrl_if.mem_mem_write;
    assign lu = ctrl_if.ex_mem_read && ctrl_if.ex_write_reg != 5'd0 &&
                (ctrl_if.ex_write_reg == ctrl_if.id_rs ||
                 (ctrl_if.id_uses_rt && ctrl_if.ex_write_reg == ctrl_if.id_rt));
    assign taken = ctrl_if.mem_branch & ctrl_if.mem_zero_flag;
    // rst gates everything so outputs return to defaults the moment reset rises
    assign freeze = !rst && !ctrl_if.dmem_ready &&
                    ((state_q == RUN && mem_acc) || state_q == MEM_WAIT);
    assign err = !rst && state_q == ERR;
    assign adv = !rst && !err && !freeze;
    assign stall = freeze | (adv & !taken & lu);
    assign ctrl_if.pc_en = !(stall | err);
    assign ctrl_if.if_id_en = !(stall | err);
    assign ctrl_if.id_ex_en = !(freeze | err);
    assign ctrl_if.ex_mem_en = !(freeze | err);
    assign ctrl_if.if_id_flush = adv & taken;
    assign ctrl_if.id_ex_flush = adv & (taken | lu);
    assign ctrl_if.ex_mem_flush = adv & taken;
    assign ctrl_if.mem_wb_flush = freeze;
    assign ctrl_if.pc_src = adv & taken;
    assign ctrl_if.dmem_req = !rst && ((state_q == RUN && mem_acc) || state_q == MEM_WAIT);
    assign ctrl_if.timeout_err = err;
    assign ctrl_if.stall_count = cnt_q;
    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        if (state_q == RUN && mem_acc && !ctrl_if.dmem_ready) begin
            state_d = MEM_WAIT;
            wait_d = 5'd1;
        end else if (state_q == MEM_WAIT) begin
            state_d = ctrl_if.dmem_ready ? RUN : (wait_q == 5'(TIMEOUT) ? ERR : MEM_WAIT);
            wait_d = ctrl_if.dmem_ready ? 5'd0 : wait_q + 5'd1;
        end
        cnt_d = ctrl_if.clr_cnt ? '0 : (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, multi-cycle sequences and randomized run against a cycle model
module tb_hazard_stall_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [10:0] DEF = 11'b1111_0000_000;
    localparam logic [10:0] FRZ = 11'b0000_0001_010;
    localparam logic [10:0] ERRV = 11'b0000_0000_001;
    logic clk = 0, rst = 0;
    int n_cmp = 0, n_fail = 0;
    hazard_stall_ctrl_if #(.CNT_W(CW)) hif();
    hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut(.clk(clk), .rst(rst), .ctrl_if(hif));
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, wr;
        logic ut, emr, br, zf, mr, mw, rdy;
        logic [10:0] outs;
        int cnt;
    } vec_t;
    vec_t vt[11];

    function automatic logic [10:0] outs();
        return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.if_id_flush, hif.id_ex_flush,
                hif.ex_mem_flush, hif.mem_wb_flush, hif.pc_src, hif.dmem_req, hif.timeout_err};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, rt, wr, input logic ut, emr, br, zf, mr, mw, rdy, clr);
        hif.id_rs = rs; hif.id_rt = rt; hif.ex_write_reg = wr; hif.id_uses_rt = ut;
        hif.ex_mem_read = emr; hif.mem_branch = br; hif.mem_zero_flag = zf;
        hif.mem_mem_read = mr; hif.mem_mem_write = mw; hif.dmem_ready = rdy; hif.clr_cnt = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // cycle-level model: "waited" counts freeze cycles of the current access
    bit m_err, m_pend;
    int m_wait, m_cnt;
    function automatic logic [10:0] model_outs(input bit r);
        bit lu, busy;
        if (r) return DEF;
        if (m_err) return ERRV;
        busy = m_pend || hif.mem_mem_read || hif.mem_mem_write;
        if (busy && !hif.dmem_ready) return FRZ;
        lu = hif.ex_mem_read && hif.ex_write_reg != 0 && (hif.ex_write_reg == hif.id_rs ||
             (hif.id_uses_rt && hif.ex_write_reg == hif.id_rt));
        if (hif.mem_branch && hif.mem_zero_flag) return {9'b1111_1110_1, busy, 1'b0};
        if (lu) return {9'b0011_0100_0, busy, 1'b0};
        return {9'b1111_0000_0, busy, 1'b0};
    endfunction

    initial begin
        logic [10:0] e;
        bit busy;
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0};
        vt[1]  = '{8, 0, 8, 0, 1, 0, 0, 0, 0, 0, 11'b0011_0100_000, 1};
        vt[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, DEF, 0};
        vt[3]  = '{3, 8, 8, 0, 1, 0, 0, 0, 0, 0, DEF, 0};
        vt[4]  = '{3, 8, 8, 1, 1, 0, 0, 0, 0, 0, 11'b0011_0100_000, 1};
        vt[5]  = '{8, 0, 8, 0, 1, 1, 1, 0, 0, 0, 11'b1111_1110_100, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, DEF, 0};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11'b1111_0000_010, 0};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 1};
        vt[9]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 11'b1111_1110_110, 0};
        vt[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0, FRZ, 1};
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        chk("reset_outs", outs(), DEF);
        chk("reset_cnt", hif.stall_count, 0);
        for (int i = 0; i < 11; i++) begin
            do_reset();
            @(negedge clk);
            set_in(vt[i].rs, vt[i].rt, vt[i].wr, vt[i].ut, vt[i].emr, vt[i].br, vt[i].zf,
                   vt[i].mr, vt[i].mw, vt[i].rdy, 0);
            #1;
            chk($sformatf("vec%0d_outs", i), outs(), vt[i].outs);
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            chk($sformatf("vec%0d_cnt", i), hif.stall_count, vt[i].cnt);
        end
        // memory wait of 3 cycles, with and without a concurrent load-use hazard
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                set_in(k ? 8 : 0, 0, k ? 8 : 0, 0, k[0], 0, 0, 1, 0, c == 3, 0);
                #1;
                chk($sformatf("memwait%0d_c%0d", k, c), outs(),
                    c < 3 ? FRZ : (k ? 11'b0011_0100_010 : 11'b1111_0000_010));
            end
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            chk($sformatf("memwait%0d_cnt", k), hif.stall_count, k ? 4 : 3);
        end
        // timeout, then reset mid-access, then a fresh access must time out at the same cycle
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int c = 0; c <= TO; c++) begin
                @(negedge clk);
                set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
                #1;
                chk($sformatf("to%0d_c%0d", k, c), outs(), FRZ);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                chk($sformatf("to%0d_err%0d", k, c), outs(), ERRV);
                chk($sformatf("to%0d_cnt%0d", k, c), hif.stall_count, TO + 1);
            end
        end
        do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("midrst_outs", outs(), DEF);
        chk("midrst_cnt", hif.stall_count, 0);
        // saturation and clear priority
        do_reset();
        @(negedge clk);
        set_in(8, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("sat_cnt", hif.stall_count, 15);
        hif.clr_cnt = 1;
        @(negedge clk);
        #1;
        chk("clr_cnt", hif.stall_count, 0);
        // randomized run
        do_reset();
        m_err = 0; m_pend = 0; m_wait = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 3);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
                   1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            #1;
            if (rst) begin
                m_err = 0; m_pend = 0; m_wait = 0; m_cnt = 0;
            end
            e = model_outs(rst);
            chk($sformatf("rnd%0d_outs", n), outs(), e);
            chk($sformatf("rnd%0d_cnt", n), hif.stall_count, m_cnt);
            if (!rst) begin
                busy = m_pend || hif.mem_mem_read || hif.mem_mem_write;
                m_cnt = hif.clr_cnt ? 0 : (!m_err && !e[10] && m_cnt < 15) ? m_cnt + 1 : m_cnt;
                if (!m_err) begin
                    if (busy && !hif.dmem_ready) begin
                        if (m_pend && m_wait == TO) m_err = 1;
                        else begin m_pend = 1; m_wait++; end
                    end else begin
                        m_pend = 0; m_wait = 0;
                    end
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
